// File: rtl/nibble_serial_adder_seq.sv
// Nibble-serial sequencer around an external 4-bit adder, LSB nibble first.
// Optional subtract mode: define NIBBLE_SUB_EN to add the in_sub port.
module nibble_serial_adder_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef NIBBLE_SUB_EN
  input  logic             in_sub,
`endif
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  input  logic             add_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NIB = WIDTH / 4;
  localparam int NW  = $clog2(NIB);
  localparam logic [NW-1:0] LAST = NW'(NIB - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [NW-1:0]    nib_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             vld_q;
  logic             rdy_q;

  logic [WIDTH-1:0] b_d;
  logic             carry_d;

  // Subtraction is a + ~b + 1 through the same adder chain.
  always_comb begin
`ifdef NIBBLE_SUB_EN
    b_d     = in_sub ? ~in_b : in_b;
    carry_d = in_sub | in_cin;
`else
    b_d     = in_b;
    carry_d = in_cin;
`endif
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == S_RUN) begin
      add_a   = a_q[{nib_q, 2'b00} +: 4];
      add_b   = b_q[{nib_q, 2'b00} +: 4];
      add_cin = carry_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      nib_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid && rdy_q) begin
            a_q     <= in_a;
            b_q     <= b_d;
            carry_q <= carry_d;
            nib_q   <= '0;
            rdy_q   <= 1'b0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          res_q[{nib_q, 2'b00} +: 4] <= add_sum;
          carry_q <= add_cout;
          if (nib_q == LAST) begin
            cout_q  <= add_cout;
            ovf_q   <= add_ovf;
            nib_q   <= '0;
            vld_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            nib_q <= nib_q + NW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign out_sum   = res_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule
